multi_modulus_div: RTL and testbench
====================================

MULTI_MODULUS_DIV -- requirements
Module: multi_modulus_div

Interface
REQ-001 The block SHALL take parameter STAGES, default 4, as the number of cascaded 2/3 stages; legal range 1..8.
REQ-002 The block SHALL divide by N = 2^STAGES + p, giving a range of 2^STAGES to 2^(STAGES+1)-1 (16..31 at the default).
REQ-003 The block SHALL have port clk_in, input, 1 bit: the sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port p, input, STAGES bits: modulus select, unsigned.
REQ-007 The block SHALL have port div_out, output, 1 bit: registered one-cycle pulse, once per division period.
REQ-008 The block SHALL have port ratio_active, output, STAGES bits: the p value governing the current period.
REQ-009 The block SHALL have port div_half, output, 1 bit: duty-corrected divided clock (see Configuration).

Function
REQ-010 Internal state SHALL be a period counter cnt, STAGES+1 bits, unsigned, plus the ratio_active register.
REQ-011 Active modulus SHALL be computed as N_act = 2^STAGES + ratio_active, with no overflow at STAGES+1 bits.
REQ-012 On an edge with en=1 and cnt < N_act-1, the block SHALL set cnt <= cnt+1 and div_out <= 0.
REQ-013 On an edge with en=1 and cnt == N_act-1 (wrap), the block SHALL set cnt <= 0, div_out <= 1 and ratio_active <= p.
REQ-014 div_out SHALL be high for exactly one clk_in cycle per wrap, and consecutive pulses SHALL be exactly N_act enabled edges apart.
REQ-015 A change on p mid-period SHALL NOT alter the current period; it SHALL take effect only for the period beginning at the next wrap.
REQ-016 On an edge with en=0, the block SHALL hold cnt and ratio_active and force div_out <= 0; each disabled cycle SHALL stretch the period by one cycle.
REQ-017 If en=0 on the edge that would wrap, the block SHALL NOT wrap; the wrap SHALL occur on the next enabled edge.
REQ-018 Latency: with en held at 1, the first div_out pulse after reset release SHALL be visible in the cycle after the N_act-th rising edge following release.
REQ-019 With p at 0 or at all-ones, the block SHALL divide by exactly 2^STAGES or 2^(STAGES+1)-1 respectively, with no skipped or extra pulses.

Reset
REQ-020 On an edge with rst=1, the block SHALL set cnt <= 0, div_out <= 0, div_half <= 0 and ratio_active <= p; rst SHALL take priority over en.
REQ-021 Reset asserted mid-period SHALL abort that period; no pulse SHALL be produced for it, and counting SHALL restart per REQ-018 after release.

Configuration
REQ-022 Macro MMD_DUTY_CORR_EN SHALL select whether the duty-corrected output is compiled in.
REQ-023 With MMD_DUTY_CORR_EN defined, div_half SHALL be registered and high for the first floor(N_act/2) cycles of each period, starting in the same cycle as div_out, and low for the remaining ceil(N_act/2) cycles.
REQ-024 With MMD_DUTY_CORR_EN defined, div_half SHALL hold its value on edges with en=0.
REQ-025 Without MMD_DUTY_CORR_EN, div_half SHALL be driven constant 0, and the port SHALL remain present.

Verification
REQ-026 STAGES=4, p=0, en=1, rst released -> div_out pulses every 16 cycles, with the first pulse after edge 16.
REQ-027 STAGES=4, p=15 -> div_out period of 31 cycles; ratio_active=15.
REQ-028 p=3, changed to 9 mid-period -> current period 19 cycles and next period 25; ratio_active updates to 9 in the pulse cycle.
REQ-029 p=5 (N=21), en low for 5 cycles mid-period -> that period is 26 cycles, no div_out while en is low, following period 21.
REQ-030 rst asserted for 1 cycle at count 10 of a 16 period -> div_out=0 the next cycle; next pulse 16 edges after release.
REQ-031 MMD_DUTY_CORR_EN defined, p=3 (N=19) -> div_half high 9 cycles, low 10 cycles, repeating; macro undefined -> div_half stays 0.

Source files
------------

// File: rtl/multi_modulus_div.sv
// multi_modulus_div: programmable divider, N = 2^STAGES + p (STAGES = 1..8).
// A single STAGES+1 bit period counter gives the same period and pulse
// behaviour as a cascade of STAGES 2/3 prescaler cells. A new ratio takes
// effect only when the counter wraps, so every period is glitch-free.
// Optional feature macro: MMD_DUTY_CORR_EN (compiles in the div_half output).
module multi_modulus_div #(
  parameter int STAGES = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic [STAGES-1:0] p,
  output logic              div_out,
  output logic [STAGES-1:0] ratio_active,
  output logic              div_half
);

  localparam int CW = STAGES + 1;

  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [STAGES-1:0] ratio_q;
  logic [STAGES-1:0] ratio_d;
  logic              div_q;
  logic              div_d;
  logic [CW-1:0]     n_act_s;
  logic [CW-1:0]     last_s;
  logic              wrap_s;

  // The MSB is always set, so N_act fits in STAGES+1 bits with no overflow.
  assign n_act_s = {1'b1, ratio_q};
  assign last_s  = n_act_s - {{STAGES{1'b0}}, 1'b1};
  assign wrap_s  = en && (cnt_q == last_s);

  // Next-state logic for the counter, the pulse and the latched ratio.
  always_comb begin
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    div_d   = 1'b0;
    if (en) begin
      if (wrap_s) begin
        cnt_d   = {CW{1'b0}};
        div_d   = 1'b1;
        ratio_d = p;
      end else begin
        cnt_d   = cnt_q + {{STAGES{1'b0}}, 1'b1};
        div_d   = 1'b0;
      end
    end else begin
      // Disabled edges stretch the period: hold everything, no pulse.
      div_d = 1'b0;
    end
  end

  // State register; reset aborts the current period and reloads the ratio.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q   <= {CW{1'b0}};
      div_q   <= 1'b0;
      ratio_q <= p;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      ratio_q <= ratio_d;
    end
  end

  assign div_out      = div_q;
  assign ratio_active = ratio_q;

`ifdef MMD_DUTY_CORR_EN
  logic          half_q;
  logic          half_d;
  logic [CW-1:0] half_len_s;
  logic [CW-1:0] cnt_inc_s;

  // floor(N_act/2) of the running period; N_act >= 2 so this is at least 1.
  assign half_len_s = {1'b0, n_act_s[CW-1:1]};
  assign cnt_inc_s  = cnt_q + {{STAGES{1'b0}}, 1'b1};

  // Rise together with div_out, fall after floor(N_act/2) cycles, hold on en=0.
  always_comb begin
    half_d = half_q;
    if (en) begin
      if (wrap_s) begin
        half_d = 1'b1;
      end else if (half_q && (cnt_inc_s == half_len_s)) begin
        half_d = 1'b0;
      end else begin
        half_d = half_q;
      end
    end else begin
      half_d = half_q;
    end
  end

  // Duty-corrected output register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      half_q <= 1'b0;
    end else begin
      half_q <= half_d;
    end
  end

  assign div_half = half_q;
`else
  assign div_half = 1'b0;
`endif

endmodule

// File: tb/tb_multi_modulus_div.sv
// Self-checking bench for multi_modulus_div (STAGES = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multi_modulus_div;

  localparam int STAGES = 4;

  logic              clk_in = 1'b0;
  logic              rst;
  logic              en;
  logic [STAGES-1:0] p;
  logic              div_out;
  logic [STAGES-1:0] ratio_active;
  logic              div_half;

  int checks = 0;
  int errors = 0;

  multi_modulus_div #(.STAGES(STAGES)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .en           (en),
    .p            (p),
    .div_out      (div_out),
    .ratio_active (ratio_active),
    .div_half     (div_half)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [STAGES-1:0] p;
    int                first;
    int                period;
    int                ratio;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Count rising edges until div_out is seen high; -1 if the budget expires.
  task automatic wait_pulse(input int budget, output int edges);
    edges = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk_in);
      if (div_out) begin
        edges = i;
        break;
      end
    end
  endtask

  // One reset edge with the given p, then release; returns with cnt at 0.
  task automatic reset_with(input logic [STAGES-1:0] pv);
    @(negedge clk_in);
    rst = 1'b1;
    en  = 1'b1;
    p   = pv;
    @(negedge clk_in);
    check("rst_div_out", int'(div_out), 0);
    check("rst_ratio", int'(ratio_active), int'(pv));
    check("rst_div_half", int'(div_half), 0);
    rst = 1'b0;
  endtask

  initial begin
    int e;
    int exp_half;
    rst = 1'b1;
    en  = 1'b1;
    p   = 4'd0;

    vecs[0] = '{p: 4'd0,  first: 16, period: 16, ratio: 0};
    vecs[1] = '{p: 4'd15, first: 31, period: 31, ratio: 15};
    vecs[2] = '{p: 4'd1,  first: 17, period: 17, ratio: 1};
    vecs[3] = '{p: 4'd7,  first: 23, period: 23, ratio: 7};
    vecs[4] = '{p: 4'd8,  first: 24, period: 24, ratio: 8};
    vecs[5] = '{p: 4'd3,  first: 19, period: 19, ratio: 3};

    // Steady-state periods for a spread of ratios, including both extremes.
    for (int v = 0; v < 6; v++) begin
      reset_with(vecs[v].p);
      wait_pulse(100, e);
      check("first_pulse", e, vecs[v].first);
      check("ratio_active", int'(ratio_active), vecs[v].ratio);
      wait_pulse(100, e);
      check("period_1", e, vecs[v].period);
      wait_pulse(100, e);
      check("period_2", e, vecs[v].period);
    end

    // Mid-period ratio change: current 19, next 25, ratio updates at the pulse.
    reset_with(4'd3);
    wait_pulse(100, e);
    check("chg_first", e, 19);
    repeat (5) @(negedge clk_in);
    p = 4'd9;
    check("chg_ratio_hold", int'(ratio_active), 3);
    wait_pulse(100, e);
    check("chg_cur_period", e, 14);
    check("chg_ratio_new", int'(ratio_active), 9);
    wait_pulse(100, e);
    check("chg_next_period", e, 25);

    // Enable low for 5 cycles mid-period: 3 + 5 + 18 = 26, then 21 again.
    reset_with(4'd5);
    wait_pulse(100, e);
    check("en_first", e, 21);
    repeat (3) @(negedge clk_in);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      check("en_low_no_pulse", int'(div_out), 0);
    end
    en = 1'b1;
    wait_pulse(100, e);
    check("en_stretch_rest", e, 18);
    wait_pulse(100, e);
    check("en_after_period", e, 21);

    // Enable low on the would-be wrap edge defers the wrap.
    repeat (20) @(negedge clk_in);
    en = 1'b0;
    repeat (2) begin
      @(negedge clk_in);
      check("wrap_deferred", int'(div_out), 0);
    end
    en = 1'b1;
    wait_pulse(100, e);
    check("wrap_on_next_en", e, 1);

    // Reset at count 10 of a 16 period.
    reset_with(4'd0);
    wait_pulse(100, e);
    check("rst10_first", e, 16);
    repeat (10) @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    check("rst10_div_out", int'(div_out), 0);
    rst = 1'b0;
    wait_pulse(100, e);
    check("rst10_restart", e, 16);

    // Reset on the edge that would wrap: that pulse must not appear.
    repeat (15) @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    check("rst15_no_pulse", int'(div_out), 0);
    rst = 1'b0;
    wait_pulse(100, e);
    check("rst15_restart", e, 16);

    // Duty-corrected output over one N=19 period (constant 0 when not built in).
    reset_with(4'd3);
    wait_pulse(100, e);
    check("duty_first", e, 19);
    for (int k = 0; k < 19; k++) begin
      if (k > 0) @(negedge clk_in);
`ifdef MMD_DUTY_CORR_EN
      exp_half = (k < 9) ? 1 : 0;
`else
      exp_half = 0;
`endif
      check("div_half", int'(div_half), exp_half);
    end
    wait_pulse(100, e);
    check("duty_period", e, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
